// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator command driver.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_OR  = 2'b10,
    OP_EQ  = 2'b11
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [7:0] operand;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_WAIT    = 2'b10,
    ST_RESPOND = 2'b11
  } state_e;

  localparam int         CMD_FIFO_DEPTH = 4;
  // OR with zero leaves the calculator accumulator untouched.
  localparam op_e        IDENTITY_OP    = OP_OR;
  localparam logic [7:0] IDENTITY_NUM   = 8'h00;

  function automatic logic [7:0] calc_apply(input logic [7:0] acc,
                                            input op_e        op,
                                            input logic [7:0] operand);
    logic [7:0] res;
    case (op)
      OP_ADD:  res = acc + operand;
      OP_SUB:  res = acc - operand;
      OP_OR:   res = acc | operand;
      OP_EQ:   res = (acc == operand) ? 8'h01 : 8'h00;
      default: res = acc;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/calc_driver_if.sv
// Command / calculator / result bundle between a command source and calc_driver.
interface calc_driver_if;
  import calc_pkg::*;

  cmd_t       CmdIn;
  logic       CmdValid;
  logic       CmdReady;
  logic [7:0] NumOut;
  logic [1:0] OpOut;
  logic       Enter;
  logic [7:0] ResultIn;
  logic [7:0] Result;
  logic       ResultValid;
  logic       ResultReady;

  modport master (
    output CmdIn, CmdValid, ResultIn, ResultReady,
    input  CmdReady, NumOut, OpOut, Enter, Result, ResultValid
  );

  modport slave (
    input  CmdIn, CmdValid, ResultIn, ResultReady,
    output CmdReady, NumOut, OpOut, Enter, Result, ResultValid
  );
endinterface

// File: rtl/calc_cmd_fifo.sv
// Count-based synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
module calc_cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // A push at full is only legal together with a pop, which frees the slot.
  assign push_ok_s = push && (!full || pop);
  assign pop_ok_s  = pop && !empty;
  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == {CW{1'b0}});
  assign pop_data  = mem_r[rd_ptr_r];

  always_ff @(posedge clock) begin
    if (!Reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/calc_driver.sv
// Queues calculator commands, issues them one at a time and hands back the result.
// Optional CALC_DRIVER_CHECK_EN adds a shadow accumulator and sticky Mismatch flag.
module calc_driver
  import calc_pkg::*;
(
  input logic           clock,
  input logic           Reset,
  calc_driver_if.slave  bus
`ifdef CALC_DRIVER_CHECK_EN
  ,
  output logic          Mismatch
`endif
);

  state_e     state_r;
  state_e     next_state_s;
  cmd_t       head_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;
  logic       push_s;
  logic       pop_s;
  logic [7:0] num_r;
  logic [7:0] num_nxt_s;
  logic [1:0] op_r;
  logic [1:0] op_nxt_s;
  logic       enter_r;
  logic       enter_nxt_s;
  logic       result_valid_r;
  logic       result_valid_nxt_s;
  logic [7:0] result_r;

  assign push_s       = bus.CmdValid && !fifo_full_s;
  assign pop_s        = (state_r == ST_IDLE) && !fifo_empty_s;
  assign bus.CmdReady = !fifo_full_s;

  calc_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .Reset     (Reset),
    .push      (push_s),
    .push_data (bus.CmdIn),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!Reset) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) next_state_s = ST_ISSUE;
        else               next_state_s = ST_IDLE;
      end
      ST_ISSUE: next_state_s = ST_WAIT;
      ST_WAIT:  next_state_s = ST_RESPOND;
      ST_RESPOND: begin
        if (bus.ResultReady) next_state_s = ST_IDLE;
        else                 next_state_s = ST_RESPOND;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the outputs can be registered.
  always_comb begin
    enter_nxt_s        = 1'b0;
    num_nxt_s          = IDENTITY_NUM;
    op_nxt_s           = IDENTITY_OP;
    result_valid_nxt_s = 1'b0;
    case (next_state_s)
      ST_ISSUE: begin
        // ISSUE is only entered from IDLE on a pop, so the FIFO head is the command.
        enter_nxt_s = 1'b1;
        num_nxt_s   = head_s.operand;
        op_nxt_s    = head_s.op;
      end
      ST_RESPOND: result_valid_nxt_s = 1'b1;
      default: begin
        enter_nxt_s        = 1'b0;
        result_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered outputs and result capture at the end of WAIT.
  always_ff @(posedge clock) begin
    if (!Reset) begin
      enter_r        <= 1'b0;
      num_r          <= IDENTITY_NUM;
      op_r           <= IDENTITY_OP;
      result_valid_r <= 1'b0;
      result_r       <= 8'h00;
    end else begin
      enter_r        <= enter_nxt_s;
      num_r          <= num_nxt_s;
      op_r           <= op_nxt_s;
      result_valid_r <= result_valid_nxt_s;
      if (state_r == ST_WAIT) result_r <= bus.ResultIn;
    end
  end

  assign bus.Enter       = enter_r;
  assign bus.NumOut      = num_r;
  assign bus.OpOut       = op_r;
  assign bus.ResultValid = result_valid_r;
  assign bus.Result      = result_r;

`ifdef CALC_DRIVER_CHECK_EN
  logic [7:0] shadow_r;
  logic       mismatch_r;

  // Shadow follows each issued command; ResultIn must match it by WAIT.
  always_ff @(posedge clock) begin
    if (!Reset) begin
      shadow_r   <= 8'h00;
      mismatch_r <= 1'b0;
    end else begin
      if (state_r == ST_ISSUE) shadow_r <= calc_apply(shadow_r, op_e'(op_r), num_r);
      if ((state_r == ST_WAIT) && (bus.ResultIn != shadow_r)) mismatch_r <= 1'b1;
    end
  end

  assign Mismatch = mismatch_r;
`endif

endmodule

// File: tb/tb_calc_driver.sv
// Directed + randomized bench for calc_driver with a looped-back calculator model.
module tb_calc_driver;
  import calc_pkg::*;

  logic clock = 1'b0;
  logic Reset;
  calc_driver_if bus();
`ifdef CALC_DRIVER_CHECK_EN
  logic Mismatch;
`endif

  calc_driver dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus)
`ifdef CALC_DRIVER_CHECK_EN
    ,
    .Mismatch (Mismatch)
`endif
  );

  always #5 clock = ~clock;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int enter_cnt = 0;

  logic [7:0] calc_acc;
  logic       corrupt_show;
  logic       corrupt_en = 1'b0;
  logic [7:0] ref_acc;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] ref_next(input logic [7:0] a, input logic [1:0] op,
                                          input logic [7:0] v);
    case (op)
      2'd0:    return a + v;
      2'd1:    return a - v;
      2'd2:    return a | v;
      default: return (a == v) ? 8'h01 : 8'h00;
    endcase
  endfunction

  // Calculator: applies the presented op on Enter; can be told to misreport once.
  always @(posedge clock) begin
    if (!Reset) begin
      calc_acc     <= 8'h00;
      corrupt_show <= 1'b0;
    end else if (bus.Enter) begin
      calc_acc     <= ref_next(calc_acc, bus.OpOut, bus.NumOut);
      corrupt_show <= corrupt_en && (bus.OpOut == 2'b01) && (bus.NumOut == 8'h01)
                      && (calc_acc == 8'h03);
    end
  end
  assign bus.ResultIn = corrupt_show ? 8'hFF : calc_acc;

  always @(posedge clock) begin
    if (bus.Enter) enter_cnt <= enter_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    Reset           = 1'b0;
    bus.CmdValid    = 1'b0;
    bus.CmdIn       = '0;
    bus.ResultReady = 1'b0;
    corrupt_en      = 1'b0;
    tick();
    tick();
    Reset   = 1'b1;
    ref_acc = 8'h00;
    exp_q.delete();
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [7:0] val);
    int n = 0;
    logic [7:0] r;
    bus.CmdIn.op      = op_e'(op);
    bus.CmdIn.operand = val;
    bus.CmdValid      = 1'b1;
    while (!bus.CmdReady && n < 50) begin
      tick();
      n++;
    end
    check("push_ready", 32'(bus.CmdReady), 32'h1);
    tick();
    bus.CmdValid = 1'b0;
    r = ref_next(ref_acc, op, val);
    ref_acc = r;
    exp_q.push_back(r);
  endtask

  task automatic collect(input string tag, output logic [7:0] got);
    int n = 0;
    logic [7:0] e;
    bus.ResultReady = 1'b1;
    while (!bus.ResultValid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(bus.ResultValid), 32'h1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    got = bus.Result;
    check(tag, 32'(got), 32'(e));
    tick();
    bus.ResultReady = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    int n0;
    int k;
    logic [1:0] rop;
    logic [7:0] rval;

    // Reset values.
    do_reset();
    check("rst_ready", 32'(bus.CmdReady), 32'h1);
    check("rst_valid", 32'(bus.ResultValid), 32'h0);
    check("rst_result", 32'(bus.Result), 32'h0);
    check("rst_enter", 32'(bus.Enter), 32'h0);
    check("rst_num", 32'(bus.NumOut), 32'h0);
    check("rst_op", 32'(bus.OpOut), 32'h2);
`ifdef CALC_DRIVER_CHECK_EN
    check("rst_mismatch", 32'(Mismatch), 32'h0);
`endif

    // Single ADD with exact issue timing.
    push_cmd(2'd0, 8'h05);
    check("t29_enter_idle", 32'(bus.Enter), 32'h0);
    tick();
    check("t29_enter_issue", 32'(bus.Enter), 32'h1);
    check("t29_num_issue", 32'(bus.NumOut), 32'h05);
    check("t29_op_issue", 32'(bus.OpOut), 32'h0);
    tick();
    check("t29_enter_wait", 32'(bus.Enter), 32'h0);
    check("t29_num_wait", 32'(bus.NumOut), 32'h00);
    check("t29_op_wait", 32'(bus.OpOut), 32'h2);
    check("t29_valid_wait", 32'(bus.ResultValid), 32'h0);
    tick();
    check("t29_valid_resp", 32'(bus.ResultValid), 32'h1);
    check("t29_result_resp", 32'(bus.Result), 32'h05);
    collect("t29_res", got);

    // Modulo-256 wrap.
    do_reset();
    push_cmd(2'd0, 8'hF0);
    push_cmd(2'd0, 8'h20);
    collect("t30_res0", got);
    collect("t30_res1", got);
    check("t30_wrap", 32'(got), 32'h10);
`ifdef CALC_DRIVER_CHECK_EN
    check("t30_mismatch", 32'(Mismatch), 32'h0);
`endif

    // Five back-to-back pushes with the consumer stalled.
    do_reset();
    for (int i = 0; i < 5; i++) push_cmd(2'(i % 4 == 3 ? 1 : 0), 8'(8'h11 * (i + 1)));
    check("t31_full", 32'(bus.CmdReady), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t31_full_hold", 32'(bus.CmdReady), 32'h0);
    end
    check("t31_one_enter", 32'(enter_cnt - n0 >= 0 ? 1 : 0), 32'h1);
    collect("t31_res0", got);
    check("t31_full_before_pop", 32'(bus.CmdReady), 32'h0);
    tick();
    check("t31_ready_after_pop", 32'(bus.CmdReady), 32'h1);
    for (int i = 1; i < 5; i++) collect("t31_res", got);
    check("t31_queue_drained", 32'(exp_q.size()), 32'h0);

    // Equal-compare.
    do_reset();
    push_cmd(2'd0, 8'h10);
    push_cmd(2'd3, 8'h10);
    push_cmd(2'd3, 8'h11);
    collect("t33_res0", got);
    collect("t33_eq_true", got);
    check("t33_eq_one", 32'(got), 32'h01);
    collect("t33_eq_false", got);
    check("t33_eq_zero", 32'(got), 32'h00);

`ifdef CALC_DRIVER_CHECK_EN
    // Corrupted calculator answer latches Mismatch.
    do_reset();
    push_cmd(2'd0, 8'h03);
    collect("t32_res0", got);
    check("t32_clean", 32'(Mismatch), 32'h0);
    corrupt_en = 1'b1;
    push_cmd(2'd1, 8'h01);
    exp_q[exp_q.size() - 1] = 8'hFF;
    collect("t32_bad", got);
    check("t32_set", 32'(Mismatch), 32'h1);
    corrupt_en = 1'b0;
    push_cmd(2'd0, 8'h01);
    collect("t32_good", got);
    check("t32_sticky", 32'(Mismatch), 32'h1);
`endif

    // Reset during WAIT with two commands queued.
    do_reset();
    push_cmd(2'd0, 8'h01);
    push_cmd(2'd0, 8'h02);
    push_cmd(2'd0, 8'h03);
    check("t34_wait_enter", 32'(bus.Enter), 32'h0);
    check("t34_wait_valid", 32'(bus.ResultValid), 32'h0);
    n0 = enter_cnt;
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    ref_acc = 8'h00;
    exp_q.delete();
    bus.ResultReady = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("t34_no_enter", 32'(enter_cnt), 32'(n0));
    check("t34_valid", 32'(bus.ResultValid), 32'h0);
    check("t34_ready", 32'(bus.CmdReady), 32'h1);
    check("t34_result", 32'(bus.Result), 32'h0);
    bus.ResultReady = 1'b0;

    // Randomized bursts against the reference accumulator.
    do_reset();
    for (int round = 0; round < 10; round++) begin
      k = int'($urandom_range(1, 4));
      for (int j = 0; j < k; j++) begin
        rop  = 2'($urandom_range(0, 3));
        rval = 8'($urandom);
        if (rop == 2'd3 && ($urandom % 2) == 0) rval = ref_acc;
        push_cmd(rop, rval);
      end
      for (int j = 0; j < k; j++) begin
        repeat ($urandom_range(0, 2)) tick();
        collect("rnd_res", got);
      end
    end
`ifdef CALC_DRIVER_CHECK_EN
    check("rnd_mismatch", 32'(Mismatch), 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
